alu_result_trace_buffer: RTL and testbench

- Downstream debug/verification capture stage attached to the processor's ALUResultOut bus.
- Timestamps selected ALU results with a free-running cycle counter and queues them in a first-word-fall-through FIFO.
- Firmware or bench logic drains the FIFO through a valid/ready read port.
- Reports overflow and counts dropped samples so trace loss is never silent.

---
 rtl/trace_pkg.sv | 12 +
 rtl/sync_fifo_fwft.sv | 60 ++++++
 rtl/alu_result_trace_buffer.sv | 114 +++++++++++
 tb/tb_alu_result_trace_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the ALU result trace buffer.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head entry is presented
// combinationally whenever the FIFO is non-empty. A push and a pop in the
// same cycle are both honoured even when full: the write lands in the slot
// the departing head is vacating.
module sync_fifo_fwft #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gate the head to zero when empty so the output is clean during reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed since only valid slots are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wr_data;
    end

    // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/alu_result_trace_buffer.sv
// Timestamped capture of ALU results into a FWFT FIFO with overflow
// accounting and an optional halt-on-first-drop mode.
module alu_result_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int TS_WIDTH     = 16,
    parameter bit STOP_ON_FULL = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic                      capture_en,
    input  logic                      change_only,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [TS_WIDTH-1:0]       rd_timestamp,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    output logic [DROP_CNT_WIDTH-1:0] drop_count,
    output logic                      halted
);

    state_t                state, state_nxt;
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] last_value;
    logic                  first_flag;
    logic                  empty;
    logic                  req;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // HALT blocks sampling; clear suppresses any request in its own cycle.
    assign req  = !clear && capture_en && (state != HALT) &&
                  (!change_only || first_flag || (alu_result_in != last_value));
    assign pop  = rd_valid && rd_ready;
    assign push = req && (!full || pop);
    assign drop = req && full && !pop;

    assign rd_valid = !empty;
    assign halted   = (state == HALT);

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + TS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data ({alu_result_in, ts}),
        .rd_data ({rd_data, rd_timestamp}),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: clear wins, a drop halts only in stop-on-full mode.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (drop && STOP_ON_FULL) state_nxt = HALT;
                      else if (capture_en)      state_nxt = RUN;
                RUN:  if (drop && STOP_ON_FULL) state_nxt = HALT;
                      else if (!capture_en)     state_nxt = IDLE;
                HALT: state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Free-running timestamp, change-detect history and drop accounting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts         <= '0;
            last_value <= '0;
            first_flag <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            ts         <= '0;
            last_value <= '0;
            first_flag <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            ts <= ts + TS_WIDTH'(1);
            if (push) begin
                last_value <= alu_result_in;
                first_flag <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_trace_buffer.sv
// Scoreboard bench: expected head entries are queued as captures are issued,
// a negedge monitor checks every pop. Two instances cover both drop modes.
module tb_alu_result_trace_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] alu = '0;
    logic        cap_en = 1'b0, cap_en1 = 1'b0;
    logic        chg = 1'b0;
    logic        rdy = 1'b0, rdy1 = 1'b0;

    logic        rd_valid, rd_valid1;
    logic [31:0] rd_data, rd_data1;
    logic [15:0] rd_ts, rd_ts1;
    logic [4:0]  count, count1;
    logic        full, full1, ovf, ovf1, halted, halted1;
    logic [15:0] drops, drops1;

    logic [15:0] tb_ts;
    logic [47:0] sb[$];
    logic [47:0] e;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    alu_result_trace_buffer #(.DATA_WIDTH(32), .DEPTH(16), .TS_WIDTH(16), .STOP_ON_FULL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .alu_result_in(alu),
        .capture_en(cap_en), .change_only(chg), .rd_ready(rdy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_timestamp(rd_ts),
        .count(count), .full(full), .overflow(ovf), .drop_count(drops), .halted(halted));

    alu_result_trace_buffer #(.DATA_WIDTH(32), .DEPTH(16), .TS_WIDTH(16), .STOP_ON_FULL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .alu_result_in(alu),
        .capture_en(cap_en1), .change_only(chg), .rd_ready(rdy1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_timestamp(rd_ts1),
        .count(count1), .full(full1), .overflow(ovf1), .drop_count(drops1), .halted(halted1));

    // Reference timestamp: counts edges since reset/clear.
    always @(posedge clk or negedge reset) begin
        if (!reset)     tb_ts <= '0;
        else if (clear) tb_ts <= '0;
        else            tb_ts <= tb_ts + 16'd1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && rd_valid && rdy) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got %0h expected none", rd_data);
            end else begin
                e = sb.pop_front();
                chk("pop_data", {32'd0, rd_data}, {32'd0, e[47:16]});
                chk("pop_ts", {48'd0, rd_ts}, {48'd0, e[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one capture cycle on dut0; queue expectation if it should land.
    task automatic cap(input logic [31:0] d, input bit keep);
        alu = d;
        cap_en = 1'b1;
        if (keep) sb.push_back({d, tb_ts});
        step();
    endtask

    logic [31:0] co_val [6] = '{32'd7, 32'd7, 32'd7, 32'd9, 32'd9, 32'd7};
    bit          co_keep[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #1;
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_flags", {ovf, halted, drops}, 0);
        #1 reset = 1'b1;

        // Basic: capture in cycle 3, one-cycle latency, then pop.
        repeat (3) step();
        alu = 32'h5;
        cap_en = 1'b1;
        sb.push_back({32'h5, 16'd3});
        step();
        cap_en = 1'b0;
        chk("basic_valid", rd_valid, 1);
        chk("basic_count", count, 1);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("basic_drained_valid", rd_valid, 0);
        chk("basic_drained_count", count, 0);

        // Change-only filter: 7,7,7,9,9,7 keeps 7,9,7.
        chg = 1'b1;
        for (int i = 0; i < 6; i++) cap(co_val[i], co_keep[i]);
        cap_en = 1'b0;
        chg = 1'b0;
        chk("chg_count", count, 3);
        rdy = 1'b1;
        repeat (3) step();
        rdy = 1'b0;
        chk("chg_drained", count, 0);

        // Full with simultaneous pop: new value becomes tail, no drop.
        for (int i = 0; i < 16; i++) cap(32'h200 + i, 1'b1);
        cap_en = 1'b0;
        chk("fill_count", count, 16);
        chk("fill_full", full, 1);
        rdy = 1'b1;
        cap(32'h2FF, 1'b1);
        cap_en = 1'b0;
        rdy = 1'b0;
        chk("fullpop_count", count, 16);
        chk("fullpop_ovf", ovf, 0);
        chk("fullpop_drops", drops, 0);
        rdy = 1'b1;
        repeat (16) step();
        rdy = 1'b0;
        chk("fullpop_drained", count, 0);

        // Overflow with keep-running: 20 captures, last 4 dropped.
        for (int i = 0; i < 20; i++) cap(32'h100 + i, i < 16);
        cap_en = 1'b0;
        chk("ovf_count", count, 16);
        chk("ovf_full", full, 1);
        chk("ovf_flag", ovf, 1);
        chk("ovf_drops", drops, 4);
        chk("ovf_not_halted", halted, 0);
        rdy = 1'b1;
        repeat (16) step();
        rdy = 1'b0;
        chk("ovf_drained", count, 0);
        chk("ovf_sticky", ovf, 1);

        // Stop-on-full instance: halt on first drop, ignore until clear.
        for (int i = 0; i < 17; i++) begin
            alu = 32'h300 + i;
            cap_en1 = 1'b1;
            step();
        end
        chk("halt_halted", halted1, 1);
        chk("halt_drops", drops1, 1);
        chk("halt_count", count1, 16);
        chk("halt_ovf", ovf1, 1);
        alu = 32'h3AA;
        step();
        alu = 32'h3BB;
        step();
        cap_en1 = 1'b0;
        chk("halt_ignore_drops", drops1, 1);
        chk("halt_head", rd_data1, 32'h300);
        rdy1 = 1'b1;
        repeat (16) step();
        rdy1 = 1'b0;
        chk("halt_drained", count1, 0);
        cap_en1 = 1'b1;
        alu = 32'h3CC;
        repeat (2) step();
        cap_en1 = 1'b0;
        chk("halt_post_drain_count", count1, 0);
        chk("halt_post_drain_drops", drops1, 1);
        chk("halt_still", halted1, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_halted", halted1, 0);
        chk("clr_count", count1, 0);
        chk("clr_ovf", {ovf1, ovf}, 0);
        chk("clr_drops", {drops1, drops}, 0);

        // Async reset mid-stream with 5 entries held.
        for (int i = 0; i < 5; i++) cap(32'h400 + i, 1'b1);
        cap_en = 1'b0;
        chk("pre_rst_count", count, 5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_ts", rd_ts, 0);
        chk("arst_data", rd_data, 0);
        step();
        reset = 1'b1;
        step();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
